// File: rtl/vregfile_rdseq_if.sv
// Handshake/bus bundle for the vector register-file read sequencer.
// Groups the command, register-file read port, write-port snoop and element output.
// slave = sequencer side, master = environment side (command source, RF, sink).
interface vregfile_rdseq_if #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 4
);
  // command
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [LOG2NUMREGS-1:0] cmd_base;
  logic [LOG2NUMREGS:0]   cmd_len;
  // register-file read port A
  logic [LOG2NUMREGS-1:0] rf_a_reg;
  logic                   rf_a_en;
  logic [WIDTH-1:0]       rf_a_readdataout;
  // register-file write-port snoop
  logic [LOG2NUMREGS-1:0] wr_reg;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_we;
  // element output
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [LOG2NUMREGS-1:0] out_idx;
  logic                   out_last;
  // status
  logic                   busy;

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, rf_a_readdataout,
           wr_reg, wr_data, wr_we, out_ready,
    output cmd_ready, rf_a_reg, rf_a_en, out_valid, out_data,
           out_idx, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_base, cmd_len, rf_a_readdataout,
           wr_reg, wr_data, wr_we, out_ready,
    input  cmd_ready, rf_a_reg, rf_a_en, out_valid, out_data,
           out_idx, out_last, busy
  );
endinterface

// File: rtl/vregfile_rdseq.sv
// Vector register-file read sequencer: streams len registers starting at base (wrapping) out as elements.
// Latency: first out_valid 3 cycles after command accept, then one element per cycle.
// Backpressure: 2-entry output FIFO; reads are only issued while FIFO+inflight would stay below 2.
// Ports: clk, resetn (synchronous, active-high), bus (slave modport: cmd_*, rf_a_*, wr_* snoop, out_*, busy).
module vregfile_rdseq #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 16,
  parameter int LOG2NUMREGS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  vregfile_rdseq_if.slave     bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LOG2NUMREGS:0] NREGS_W = (LOG2NUMREGS+1)'(NUMREGS);

  logic [1:0]             state;
  logic [LOG2NUMREGS-1:0] base_q;
  logic [LOG2NUMREGS:0]   len_q;
  logic [LOG2NUMREGS:0]   cnt_q;

  // element whose read was issued last cycle (data arrives this cycle)
  logic                   inflight_q;
  logic [LOG2NUMREGS-1:0] infl_idx_q;
  logic                   infl_last_q;
  logic                   byp_vld_q;
  logic [WIDTH-1:0]       byp_dat_q;

  // 2-entry output FIFO
  logic [WIDTH-1:0]       fifo_dat  [2];
  logic [LOG2NUMREGS-1:0] fifo_idx  [2];
  logic                   fifo_last [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             fifo_cnt;

  logic [LOG2NUMREGS:0]   addr_sum;
  logic [1:0]             occupancy;
  logic                   pop;
  logic                   can_issue;
  logic                   last_issue;

  // base + i can reach 2*NUMREGS-2, so one subtraction is enough for the wrap
  assign addr_sum     = {1'b0, base_q} + cnt_q;
  assign bus.rf_a_reg = LOG2NUMREGS'((addr_sum >= NREGS_W) ? addr_sum - NREGS_W : addr_sum);

  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = fifo_dat[rd_ptr];
  assign bus.out_idx   = fifo_idx[rd_ptr];
  assign bus.out_last  = fifo_last[rd_ptr];
  assign pop           = bus.out_valid & bus.out_ready;

  // a slot freed by this cycle's pop may be reused by this cycle's issue
  assign occupancy  = fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign can_issue  = (state == S_RUN) && (occupancy < 2'd2);
  assign last_issue = (cnt_q == len_q - 1'b1);

  assign bus.rf_a_en   = can_issue;
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (resetn) begin
      state       <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      byp_vld_q   <= 1'b0;
      byp_dat_q   <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        fifo_dat[k]  <= '0;
        fifo_idx[k]  <= '0;
        fifo_last[k] <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_len != '0) begin
            base_q <= bus.cmd_base;
            len_q  <= bus.cmd_len;
            cnt_q  <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (can_issue) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_issue) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_cnt == 2'd0 && !inflight_q) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      inflight_q  <= can_issue;
      infl_idx_q  <= cnt_q[LOG2NUMREGS-1:0];
      infl_last_q <= last_issue;
      // the RF returns old data on a same-cycle write, so capture the new value here
      byp_vld_q   <= bus.wr_we && (bus.wr_reg == bus.rf_a_reg);
      byp_dat_q   <= bus.wr_data;

      if (inflight_q) begin
        fifo_dat[wr_ptr]  <= byp_vld_q ? byp_dat_q : bus.rf_a_readdataout;
        fifo_idx[wr_ptr]  <= infl_idx_q;
        fifo_last[wr_ptr] <= infl_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule
